spi_ram_slave: RTL and testbench

- SPI slave front end that is the initiator on the RAM port.
- Deserialises 10-bit MOSI frames into the RAM's din/rx_valid inputs.
- Captures the RAM's dout/tx_valid read response and serialises it MSB-first on MISO.
- Sits between the external SPI master and the RAM; SCK is the system clock clk.

---
 rtl/RAM_shared_pkg.sv | 18 +
 rtl/spi_ram_slave_shift_out.sv | 59 +++++
 rtl/spi_ram_slave.sv | 97 +++++++++
 tb/tb_spi_ram_slave.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/RAM_shared_pkg.sv
// RAM_shared_pkg: shared RAM geometry, SPI slave FSM states and frame command codes.
package RAM_shared_pkg;
    localparam int ADDR_SIZE = 8;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_ram_slave_shift_out.sv
// spi_ram_slave_shift_out: W-bit load/shift-out register driving a registered MSB-first serial line.
module spi_ram_slave_shift_out #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         miso_o,
    output logic         busy_o
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          miso_q, miso_d;

    // The MSB goes out right after the load; cnt_q tracks the bits still queued behind it.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        miso_d = 1'b0;
        if (clr_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (load_i && !busy_q) begin
            sreg_d = data_i << 1;
            miso_d = data_i[W-1];
            cnt_d  = CW'(W - 1);
            busy_d = 1'b1;
        end else if (busy_q && cnt_q != '0) begin
            miso_d = sreg_q[W-1];
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q - 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            miso_q <= miso_d;
        end
    end

    assign miso_o = miso_q;
    assign busy_o = busy_q;
endmodule

// File: rtl/spi_ram_slave.sv
// spi_ram_slave: SPI slave that deserialises command frames for the RAM and serialises its read data.
module spi_ram_slave #(
    parameter int ADDR_SIZE = RAM_shared_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    import RAM_shared_pkg::*;

    localparam int FW = ADDR_SIZE + 2;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] LAST = CW'(FW - 1);
    localparam logic [CW-1:0] DONE = CW'(FW);

    state_e        state_q;
    logic [FW-1:0] rx_data_q;
    logic [CW-1:0] cnt_q;
    logic          rx_valid_q;
    logic          rd_addr_done_q;
    logic          awaiting_q;
    logic          load;
    logic          busy;

    // cnt_q counts sampled frame bits; DONE means the frame is closed until SS_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rx_data_q      <= '0;
            cnt_q          <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            awaiting_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (SS_n) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                awaiting_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= CHK_CMD;
                        cnt_q   <= '0;
                    end
                    CHK_CMD: begin
                        rx_data_q <= {rx_data_q[FW-2:0], MOSI};
                        cnt_q     <= CW'(1);
                        state_q   <= !MOSI ? WRITE : (rd_addr_done_q ? READ_DATA : READ_ADD);
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (cnt_q != DONE) begin
                            rx_data_q <= {rx_data_q[FW-2:0], MOSI};
                            cnt_q     <= cnt_q + 1'b1;
                            if (cnt_q == LAST) begin
                                rx_valid_q <= 1'b1;
                                if (state_q == READ_ADD)
                                    rd_addr_done_q <= 1'b1;
                                if (state_q == READ_DATA) begin
                                    rd_addr_done_q <= 1'b0;
                                    awaiting_q     <= 1'b1;
                                end
                            end
                        end else if (load) begin
                            awaiting_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign load = awaiting_q && tx_valid && !SS_n;

    spi_ram_slave_shift_out #(.W(ADDR_SIZE)) u_shift_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (SS_n),
        .load_i (load),
        .data_i (tx_data),
        .miso_o (MISO),
        .busy_o (busy)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    logic unused_busy;
    assign unused_busy = busy;
endmodule

// File: tb/tb_spi_ram_slave.sv
// tb_spi_ram_slave: directed-vector bench for spi_ram_slave with hand-computed expectations.
module tb_spi_ram_slave;
    import RAM_shared_pkg::*;

    localparam int FW = ADDR_SIZE + 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 SS_n = 1'b1;
    logic                 MOSI = 1'b0;
    logic                 MISO;
    logic [FW-1:0]        rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data = '0;
    logic                 tx_valid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    int base;
    logic [7:0] pat;

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_valid) pulses++;

    spi_ram_slave #(.ADDR_SIZE(ADDR_SIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frame(input logic [FW-1:0] f);
        SS_n = 1'b0;
        @(negedge clk);
        for (int i = FW - 1; i >= 0; i--) begin
            MOSI = f[i];
            @(negedge clk);
        end
    endtask

    task automatic release_ss();
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", dut.state_q, IDLE);
        check("rst_miso", MISO, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rd_done", dut.rd_addr_done_q, 0);
        rst_n = 1'b1;
        @(negedge clk);

        base = pulses;
        frame(10'h005);
        check("wa_rx_valid", rx_valid, 1);
        check("wa_rx_data", rx_data, 10'h005);
        check("wa_state", dut.state_q, WRITE);
        check("wa_rd_done", dut.rd_addr_done_q, 0);
        @(negedge clk);
        check("wa_rx_valid_drop", rx_valid, 0);
        check("wa_pulses", pulses - base, 1);
        release_ss();

        base = pulses;
        frame(10'h1AA);
        check("wd_rx_valid", rx_valid, 1);
        check("wd_rx_data", rx_data, 10'h1AA);
        tx_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            MOSI = i[0];
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("wd_pulses", pulses - base, 1);
        check("wd_rx_hold", rx_data, 10'h1AA);
        check("wd_stray_tx_miso", MISO, 0);
        release_ss();
        check("ss_idle", dut.state_q, IDLE);

        frame(10'h205);
        check("ra_rx_data", rx_data, 10'h205);
        check("ra_state", dut.state_q, READ_ADD);
        check("ra_rd_done", dut.rd_addr_done_q, 1);
        release_ss();

        frame(10'h3FF);
        check("rd_rx_valid", rx_valid, 1);
        check("rd_rx_data", rx_data, 10'h3FF);
        check("rd_state", dut.state_q, READ_DATA);
        check("rd_rd_done", dut.rd_addr_done_q, 0);
        repeat (2) @(negedge clk);
        check("rd_wait_miso", MISO, 0);
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        pat = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            check("rd_miso_bit", MISO, pat[i]);
            tx_valid = (i == 4);
            tx_data = 8'h00;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("rd_miso_tail", MISO, 0);
        @(negedge clk);
        check("rd_miso_tail2", MISO, 0);
        check("rd_rd_done_after", dut.rd_addr_done_q, 0);
        release_ss();

        base = pulses;
        SS_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            MOSI = (i != 0);
            @(negedge clk);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        check("ab_state", dut.state_q, IDLE);
        @(negedge clk);
        check("ab_pulses", pulses - base, 0);
        check("ab_rd_done", dut.rd_addr_done_q, 0);
        frame(10'h0F0);
        check("ab_next_valid", rx_valid, 1);
        check("ab_next_data", rx_data, 10'h0F0);
        release_ss();

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(10'h2A5);
        check("nr_state", dut.state_q, READ_ADD);
        check("nr_rd_done", dut.rd_addr_done_q, 1);
        check("nr_rx_data", rx_data, 10'h2A5);
        release_ss();

        frame(10'h300);
        check("mr_state", dut.state_q, READ_DATA);
        @(negedge clk);
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("mr_bit7", MISO, 0);
        @(negedge clk);
        check("mr_bit6", MISO, 1);
        @(negedge clk);
        check("mr_bit5", MISO, 0);
        @(negedge clk);
        check("mr_bit4", MISO, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mr_rst_miso", MISO, 0);
        check("mr_rst_state", dut.state_q, IDLE);
        check("mr_rst_rd_done", dut.rd_addr_done_q, 0);
        check("mr_rst_rx_data", rx_data, 0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
